divider_arbiter: RTL and testbench
==================================

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameter N_REQ, 2, number of requesters sharing one divider (2..8) SHALL be supported.
REQ-002 Parameter DIV_BITS, 32, operand/result width SHALL match the shared divider.
REQ-003 clk  in  1  sole clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset SHALL be sampled on posedge clk.
REQ-005 req_valid  in  N_REQ  per-requester divide request SHALL be an input.
REQ-006 req_ready  out  N_REQ  one-hot acceptance pulse SHALL be an output.
REQ-007 req_numerator, req_denominator  in  N_REQ*DIV_BITS  packed operands SHALL be inputs, requester i at bits [i*DIV_BITS +: DIV_BITS].
REQ-008 req_numerator_signed  in  N_REQ  per-requester signed-numerator flag SHALL be an input.
REQ-009 resp_valid  out  N_REQ  one-hot result pulse SHALL be an output.
REQ-010 resp_quotient, resp_remainder  out  DIV_BITS  result SHALL be valid when any resp_valid bit is set.
REQ-011 div_numerator, div_denominator  out  DIV_BITS; div_numerator_signed, div_start  out  1  SHALL form the divider command port.
REQ-012 div_busy, div_result_valid  in  1; div_quotient, div_remainder  in  DIV_BITS  SHALL form the divider status port.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT_RESULT, RESPOND.
REQ-014 IDLE: when any req_valid is set, the arbiter SHALL grant the first set bit at or after rr_ptr (wrapping modulo N_REQ), pulse req_ready[grant] for that single cycle, latch the grant's operands and flag, and go to ISSUE.
REQ-015 A requester SHALL hold req_valid and operands stable until req_ready; operands are sampled only in the accept cycle.
REQ-016 ISSUE: div_start SHALL be 1 with the latched operands until div_busy=1 is sampled, then 0 in the next cycle with a transition to WAIT_RESULT.
REQ-017 WAIT_RESULT: on div_result_valid=1, the arbiter SHALL capture div_quotient/div_remainder and go to RESPOND.
REQ-018 RESPOND: resp_valid[grant] SHALL be 1 for exactly one cycle, rr_ptr SHALL become (grant+1) mod N_REQ, and the FSM SHALL return to IDLE.
REQ-019 Latency: accept->resp_valid SHALL be divider latency + 3 cycles minimum; the arbiter SHALL accept no new request until RESPOND has completed.
REQ-020 Divide-by-zero: a latched denominator of 0 SHALL bypass the divider (no div_start) and go directly to RESPOND with quotient = all ones and remainder = the latched numerator.
REQ-021 div_result_valid or div_busy asserted in IDLE or RESPOND SHALL be ignored.
REQ-022 Simultaneous requests SHALL be served round-robin; a continuously requesting port SHALL wait at most N_REQ-1 grants.
REQ-023 resp_quotient/resp_remainder SHALL hold their last value outside RESPOND.
REQ-024 At most one req_ready bit and at most one resp_valid bit SHALL be high in any cycle.

Reset
REQ-025 While rst=1: state=IDLE, rr_ptr=0, and req_ready, resp_valid, resp_quotient, resp_remainder, div_start, div_numerator, div_denominator and div_numerator_signed SHALL all be 0.
REQ-026 rst during ISSUE or WAIT_RESULT SHALL abandon the operation: no resp_valid for it, div_start=0 the cycle after, and a later stale div_result_valid ignored per REQ-021.

Verification
REQ-027 Single request: req0 num=100, den=7, unsigned -> one req_ready[0] pulse, one div_start burst, resp_valid[0] with q=14, r=2.
REQ-028 Contention: req0 and req1 asserted together from reset -> req0 served first, then req1; with both held, grants alternate 0,1,0,1.
REQ-029 Signed: num=-50 (signed), den=5 -> flag forwarded as 1, resp q=-10 (0xFFFFFFF6), r=0.
REQ-030 Divide-by-zero: num=0x1234, den=0 -> div_start never asserted, resp q=0xFFFFFFFF, r=0x1234, within 3 cycles of accept.
REQ-031 Reset mid-op: rst pulsed during WAIT_RESULT, then divider returns result_valid -> no resp_valid, outputs at reset values, next request served normally.

Source files
------------

// File: rtl/divider_arbiter_if.sv
// ============================================================================
// Module   : divider_arbiter_if
// Brief    : Requester and shared-divider signal bundle for divider_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface divider_arbiter_if #(
  parameter int N_REQ    = 2,
  parameter int DIV_BITS = 32
);
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*DIV_BITS-1:0] req_numerator;
  logic [N_REQ*DIV_BITS-1:0] req_denominator;
  logic [N_REQ-1:0]          req_numerator_signed;
  logic [N_REQ-1:0]          resp_valid;
  logic [DIV_BITS-1:0]       resp_quotient;
  logic [DIV_BITS-1:0]       resp_remainder;

  logic [DIV_BITS-1:0]       div_numerator;
  logic [DIV_BITS-1:0]       div_denominator;
  logic                      div_numerator_signed;
  logic                      div_start;
  logic                      div_busy;
  logic                      div_result_valid;
  logic [DIV_BITS-1:0]       div_quotient;
  logic [DIV_BITS-1:0]       div_remainder;

  // Arbiter view: takes requests and divider status, drives grants and commands.
  modport slave (
    input  req_valid, req_numerator, req_denominator, req_numerator_signed,
    input  div_busy, div_result_valid, div_quotient, div_remainder,
    output req_ready, resp_valid, resp_quotient, resp_remainder,
    output div_numerator, div_denominator, div_numerator_signed, div_start
  );

  modport master (
    output req_valid, req_numerator, req_denominator, req_numerator_signed,
    output div_busy, div_result_valid, div_quotient, div_remainder,
    input  req_ready, resp_valid, resp_quotient, resp_remainder,
    input  div_numerator, div_denominator, div_numerator_signed, div_start
  );
endinterface

`default_nettype wire

// File: rtl/divider_arbiter.sv
// ============================================================================
// Module   : divider_arbiter
// Brief    : Round-robin arbiter sharing one divider among N_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_arbiter #(
  parameter int N_REQ    = 2,
  parameter int DIV_BITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  divider_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] c_IDLE        = 2'd0;
  localparam logic [1:0] c_ISSUE       = 2'd1;
  localparam logic [1:0] c_WAIT_RESULT = 2'd2;
  localparam logic [1:0] c_RESPOND     = 2'd3;

  localparam logic [N_REQ-1:0] c_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(N_REQ - 1);

  logic [1:0]          r_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_grant;
  logic                r_div_start;
  logic [DIV_BITS-1:0] r_div_num;
  logic [DIV_BITS-1:0] r_div_den;
  logic                r_div_signed;
  logic [DIV_BITS-1:0] r_resp_q;
  logic [DIV_BITS-1:0] r_resp_r;

  logic                w_found;
  logic [PTR_W-1:0]    w_grant_idx;
  logic [DIV_BITS-1:0] w_sel_num;
  logic [DIV_BITS-1:0] w_sel_den;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && bus.req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_found     = 1'b1;
        w_grant_idx = PTR_W'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_sel_num = bus.req_numerator[w_grant_idx*DIV_BITS +: DIV_BITS];
  assign w_sel_den = bus.req_denominator[w_grant_idx*DIV_BITS +: DIV_BITS];

  assign bus.req_ready  = (!rst && r_state == c_IDLE && w_found) ? (c_ONE << w_grant_idx) : '0;
  assign bus.resp_valid = (!rst && r_state == c_RESPOND) ? (c_ONE << r_grant) : '0;

  assign bus.resp_quotient        = r_resp_q;
  assign bus.resp_remainder       = r_resp_r;
  assign bus.div_numerator        = r_div_num;
  assign bus.div_denominator      = r_div_den;
  assign bus.div_numerator_signed = r_div_signed;
  assign bus.div_start            = r_div_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_div_start  <= 1'b0;
      r_div_num    <= '0;
      r_div_den    <= '0;
      r_div_signed <= 1'b0;
      r_resp_q     <= '0;
      r_resp_r     <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_grant      <= w_grant_idx;
            r_div_num    <= w_sel_num;
            r_div_den    <= w_sel_den;
            r_div_signed <= bus.req_numerator_signed[w_grant_idx];
            // A zero divisor never reaches the divider.
            r_div_start  <= (w_sel_den != '0);
            r_state      <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          if (r_div_den == '0) begin
            r_resp_q <= '1;
            r_resp_r <= r_div_num;
            r_state  <= c_RESPOND;
          end else if (bus.div_busy) begin
            r_div_start <= 1'b0;
            r_state     <= c_WAIT_RESULT;
          end
        end
        c_WAIT_RESULT: begin
          if (bus.div_result_valid) begin
            r_resp_q <= bus.div_quotient;
            r_resp_r <= bus.div_remainder;
            r_state  <= c_RESPOND;
          end
        end
        c_RESPOND: begin
          r_rr_ptr <= (r_grant == c_LAST) ? '0 : r_grant + 1'b1;
          r_state  <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider_arbiter.sv
// ============================================================================
// Module   : tb_divider_arbiter
// Brief    : Directed self-checking bench for divider_arbiter with a divider stub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_arbiter;

  localparam int NR = 2;
  localparam int DB = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divider_arbiter_if #(.N_REQ(NR), .DIV_BITS(DB)) bus ();
  divider_arbiter #(.N_REQ(NR), .DIV_BITS(DB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // Divider stub: fixed 4-cycle busy window, unaffected by the arbiter reset.
  logic        s_busy  = 1'b0;
  logic        s_rv    = 1'b0;
  logic [31:0] s_q     = '0;
  logic [31:0] s_r     = '0;
  logic [31:0] s_num   = '0;
  logic [31:0] s_den   = '0;
  logic        s_sgn   = 1'b0;
  int          s_cnt   = 0;

  assign bus.div_busy         = s_busy;
  assign bus.div_result_valid = s_rv;
  assign bus.div_quotient     = s_q;
  assign bus.div_remainder    = s_r;

  always @(posedge clk) begin
    s_rv <= 1'b0;
    if (!s_busy && bus.div_start) begin
      s_busy <= 1'b1;
      s_cnt  <= 4;
      s_num  <= bus.div_numerator;
      s_den  <= bus.div_denominator;
      s_sgn  <= bus.div_numerator_signed;
    end else if (s_busy) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) begin
        s_busy <= 1'b0;
        s_rv   <= 1'b1;
        if (s_sgn) begin
          s_q <= $signed(s_num) / $signed(s_den);
          s_r <= $signed(s_num) % $signed(s_den);
        end else begin
          s_q <= s_num / s_den;
          s_r <= s_num % s_den;
        end
      end
    end
  end

  int   start_rises = 0;
  int   resp_cnt    = 0;
  int   ready_cnt   = 0;
  logic prev_start  = 1'b0;

  always @(negedge clk) begin
    if (bus.div_start && !prev_start) start_rises++;
    prev_start = bus.div_start;
    if (bus.resp_valid != '0) resp_cnt++;
    if (bus.req_ready != '0) ready_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [31:0] num, input logic [31:0] den, input logic sgn);
    bus.req_numerator[p*DB +: DB]   = num;
    bus.req_denominator[p*DB +: DB] = den;
    bus.req_numerator_signed[p]     = sgn;
  endtask

  task automatic wait_resp(input string tag, input int budget, output int n);
    n = 0;
    while (bus.resp_valid == '0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(bus.resp_valid != '0), 64'd1);
  endtask

  int n;
  int m;
  int b_start;
  int b_resp;
  int b_ready;

  initial begin
    bus.req_valid            = '0;
    bus.req_numerator        = '0;
    bus.req_denominator      = '0;
    bus.req_numerator_signed = '0;
    rst = 1'b1;
    repeat (3) tick();

    check("rst_ready",     64'(bus.req_ready), 64'd0);
    check("rst_resp",      64'(bus.resp_valid), 64'd0);
    check("rst_start",     64'(bus.div_start), 64'd0);
    check("rst_q",         64'(bus.resp_quotient), 64'd0);
    check("rst_r",         64'(bus.resp_remainder), 64'd0);
    check("rst_div_num",   64'(bus.div_numerator), 64'd0);
    check("rst_div_den",   64'(bus.div_denominator), 64'd0);
    check("rst_div_sgn",   64'(bus.div_numerator_signed), 64'd0);

    rst = 1'b0;
    tick();

    // Single unsigned request: 100 / 7
    b_start = start_rises; b_resp = resp_cnt; b_ready = ready_cnt;
    set_req(0, 32'd100, 32'd7, 1'b0);
    bus.req_valid = 2'b01;
    #1;
    check("t1_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b00;
    #1;
    check("t1_ready_drop", 64'(bus.req_ready), 64'h0);
    check("t1_start",      64'(bus.div_start), 64'h1);
    check("t1_div_num",    64'(bus.div_numerator), 64'd100);
    check("t1_div_den",    64'(bus.div_denominator), 64'd7);
    check("t1_div_sgn",    64'(bus.div_numerator_signed), 64'h0);
    wait_resp("t1_resp_seen", 20, n);
    check("t1_latency_min", 64'(n >= 3), 64'd1);
    check("t1_resp_valid", 64'(bus.resp_valid), 64'h1);
    check("t1_q", 64'(bus.resp_quotient), 64'd14);
    check("t1_r", 64'(bus.resp_remainder), 64'd2);
    tick();
    check("t1_resp_drop", 64'(bus.resp_valid), 64'h0);
    check("t1_q_hold",    64'(bus.resp_quotient), 64'd14);
    check("t1_start_bursts", 64'(start_rises - b_start), 64'd1);
    check("t1_ready_pulses", 64'(ready_cnt - b_ready), 64'd1);
    check("t1_resp_pulses",  64'(resp_cnt - b_resp), 64'd1);

    // Contention from reset: 20/3 on port 0, 90/9 on port 1, both held
    rst = 1'b1;
    set_req(0, 32'd20, 32'd3, 1'b0);
    set_req(1, 32'd90, 32'd9, 1'b0);
    bus.req_valid = 2'b11;
    tick();
    #1;
    check("cont_rst_ready", 64'(bus.req_ready), 64'h0);
    rst = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      m = 0;
      while (bus.req_ready == '0 && m < 20) begin
        tick();
        m++;
      end
      check("cont_ready_seen", 64'(bus.req_ready != '0), 64'd1);
      check("cont_grant", 64'(bus.req_ready), (g % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      wait_resp("cont_resp_seen", 20, n);
      check("cont_resp_port", 64'(bus.resp_valid), (g % 2 == 0) ? 64'h1 : 64'h2);
      check("cont_q", 64'(bus.resp_quotient), (g % 2 == 0) ? 64'd6 : 64'd10);
      check("cont_r", 64'(bus.resp_remainder), (g % 2 == 0) ? 64'd2 : 64'd0);
      tick();
    end
    bus.req_valid = 2'b00;
    tick();

    // Signed numerator: -50 / 5 on port 1
    set_req(1, 32'hFFFF_FFCE, 32'd5, 1'b1);
    bus.req_valid = 2'b10;
    #1;
    check("sgn_ready", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 2'b00;
    #1;
    check("sgn_flag", 64'(bus.div_numerator_signed), 64'h1);
    check("sgn_div_num", 64'(bus.div_numerator), 64'hFFFF_FFCE);
    wait_resp("sgn_resp_seen", 20, n);
    check("sgn_resp_port", 64'(bus.resp_valid), 64'h2);
    check("sgn_q", 64'(bus.resp_quotient), 64'hFFFF_FFF6);
    check("sgn_r", 64'(bus.resp_remainder), 64'h0);
    tick();

    // Divide by zero: 0x1234 / 0 on port 0
    b_start = start_rises;
    set_req(0, 32'h1234, 32'h0, 1'b0);
    bus.req_valid = 2'b01;
    #1;
    check("dz_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b00;
    #1;
    check("dz_no_start", 64'(bus.div_start), 64'h0);
    wait_resp("dz_resp_within_3", 3, n);
    check("dz_resp_port", 64'(bus.resp_valid), 64'h1);
    check("dz_q", 64'(bus.resp_quotient), 64'hFFFF_FFFF);
    check("dz_r", 64'(bus.resp_remainder), 64'h1234);
    tick();
    check("dz_start_bursts", 64'(start_rises - b_start), 64'd0);

    // Reset during WAIT_RESULT, stale result must be ignored
    set_req(0, 32'd100, 32'd7, 1'b0);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mid_start", 64'(bus.div_start), 64'h0);
    check("mid_q", 64'(bus.resp_quotient), 64'h0);
    check("mid_r", 64'(bus.resp_remainder), 64'h0);
    check("mid_div_num", 64'(bus.div_numerator), 64'h0);
    rst = 1'b0;
    b_resp = resp_cnt;
    repeat (8) tick();
    check("mid_no_resp", 64'(resp_cnt - b_resp), 64'd0);
    check("mid_q_idle", 64'(bus.resp_quotient), 64'h0);

    set_req(1, 32'd81, 32'd9, 1'b0);
    bus.req_valid = 2'b10;
    #1;
    check("post_ready", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 2'b00;
    wait_resp("post_resp_seen", 20, n);
    check("post_resp_port", 64'(bus.resp_valid), 64'h2);
    check("post_q", 64'(bus.resp_quotient), 64'd9);
    check("post_r", 64'(bus.resp_remainder), 64'd0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
